renkon_linebuf_ctrl: RTL
========================

Name: renkon_linebuf_ctrl

Overview:
Sequencer for renkon_linebuf_pad. It takes one layer command (base address, image/filter/pad sizes, input-channel count) and runs the line buffer once per input channel. Per channel it latches geometry, pulses buf_req, and generates feature-memory read addresses while buf_ready is high. It also counts emitted windows into (row, col, channel) tags for the downstream MAC array, then pulses ack after the last channel.

Parameters:
DWIDTH, 16, data width (from renkon.svh)
LWIDTH, 10, image/filter/pad size width (from renkon.svh)
MEMWIDTH, 16, feature-memory address width
CHWIDTH, 8, channel-count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  start pulse, sampled only in S_IDLE
ack  out  1  one-cycle done pulse
img_size  in  LWIDTH  input plane side
fil_size  in  LWIDTH  filter side
pad_size  in  LWIDTH  zero-pad width
n_in  in  CHWIDTH  number of input channels
in_base  in  MEMWIDTH  address of channel 0, pixel 0
err  out  1  sticky config/count error, cleared on accepted req
buf_req  out  1  one-cycle start pulse to line buffer
buf_img_size  out  LWIDTH  latched img_size
buf_fil_size  out  LWIDTH  latched fil_size
buf_pad_size  out  LWIDTH  latched pad_size
buf_ready  in  1  line buffer consumes current buf_input this cycle
buf_valid  in  1  line buffer window valid
buf_ack  in  1  line buffer finished plane
mem_addr  out  MEMWIDTH  feature-memory read address (1-cycle read latency, data goes straight to buf_input)
win_valid  out  1  registered copy of buf_valid
win_row  out  LWIDTH  output row of current window
win_col  out  LWIDTH  output col of current window
win_ch  out  CHWIDTH  channel of current window
win_last  out  1  window is last of last channel

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters 0. rst mid-operation aborts immediately with no ack; buf_req is never re-pulsed.
- Derived values, registered in S_LOAD: plane = img*img (2*LWIDTH bits); odim = img + 2*pad - fil + 1 (LWIDTH+1 bits, signed check).
- S_IDLE: on req, latch all inputs, clear err, go to S_LOAD.
- S_LOAD: compute plane/odim.
  - If n_in==0: go to S_DONE.
  - If fil>img+2*pad or fil==0: set err, go to S_DONE.
  - Otherwise go to S_REQ.
- S_REQ: buf_req=1 for exactly one cycle; pix=0; mem_addr = chan_base. Go to S_FEED.
- S_FEED:
  - Each cycle with buf_ready=1, pix increments, saturating at plane-1; mem_addr = chan_base + pix.
  - On buf_ready with pix==plane-1, mem_addr holds, so the last pixel is repeated. The line buffer must not see an out-of-plane read.
  - On buf_valid: win_valid=1 next cycle with the current (row, col, ch). Then col++; at odim-1, col wraps to 0 and row++.
  - On buf_ack: go to S_NEXT. If buf_valid and buf_ack coincide, the window is counted first.
- S_NEXT:
  - If window count != odim*odim: set err.
  - chan_base += plane; ch++; row=col=0.
  - If ch==n_in-1 before the increment, go to S_DONE; else go to S_REQ.
- S_DONE: ack=1 for one cycle, then S_IDLE.
- win_last = win_valid on the final window of channel n_in-1.
- Address arithmetic wraps modulo 2^MEMWIDTH; no overflow flag.
- req outside S_IDLE is ignored.

Decomposition:
- Package renkon_pkg (renkon.svh): state enum (S_IDLE, S_LOAD, S_REQ, S_FEED, S_NEXT, S_DONE), DWIDTH/LWIDTH.
- One sub-module renkon_win_counter: row/col counter with odim wrap, clear, count output.

Test Plan:
- img=32, fil=5, pad=2, n_in=1, in_base=0 against renkon_linebuf_pad -> one buf_req; mem_addr 0..1023; 1024 win_valid; last tag (31,31,0) with win_last=1; ack once; err=0.
- img=8, fil=3, pad=0, n_in=3, in_base=0x100 -> planes start at 0x100, 0x140, 0x180; 36 windows per channel; win_ch 0,1,2; three buf_req pulses; one ack.
- n_in=0 -> no buf_req; ack 2 cycles after req; err=0.
- img=4, fil=9, pad=2 -> err=1, no buf_req, ack pulses; next valid req clears err.
- Fake line buffer asserts buf_ack after only 10 valids (img=8, fil=3, pad=0) -> err=1 after that channel; sequencing continues to ack.
- rst asserted mid-S_FEED, then new req -> outputs 0 after reset; fresh run completes normally from ch 0, address in_base.

Source files
------------

// File: rtl/renkon_pkg.sv
// -----------------------------------------------------------------------------
// renkon_pkg
// Shared widths and the sequencer state encoding for the renkon line-buffer
// control path.
//   DWIDTH   : pixel data width
//   LWIDTH   : image / filter / pad size width
//   CNTWIDTH : window-count width, wide enough for odim*odim with odim on
//              LWIDTH+1 bits
//   state_e  : sequencer states, idle -> load -> (req -> feed -> next)* -> done
// -----------------------------------------------------------------------------
package renkon_pkg;

  localparam int DWIDTH   = 16;
  localparam int LWIDTH   = 10;
  localparam int CNTWIDTH = 2 * LWIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_FEED,
    S_NEXT,
    S_DONE
  } state_e;

endpackage : renkon_pkg

// File: rtl/renkon_win_counter.sv
// -----------------------------------------------------------------------------
// renkon_win_counter
// Row/column tag counter for output windows of one plane. Column wraps at
// odim-1 and bumps the row; a running count of windows is kept so the
// sequencer can verify that the line buffer produced a full plane.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : return row, col and count to zero (has priority over inc_i)
//   inc_i    : one window was emitted this cycle
//   odim_i   : output side length
//   row_o    : row tag of the next window
//   col_o    : column tag of the next window
//   count_o  : windows counted since the last clear
//   last_o   : current (row, col) is the bottom-right window of the plane
// -----------------------------------------------------------------------------
module renkon_win_counter
  import renkon_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [LWIDTH:0]     odim_i,
  output logic [LWIDTH-1:0]   row_o,
  output logic [LWIDTH-1:0]   col_o,
  output logic [CNTWIDTH-1:0] count_o,
  output logic                last_o
);

  logic [LWIDTH-1:0]   row_q, row_d;
  logic [LWIDTH-1:0]   col_q, col_d;
  logic [CNTWIDTH-1:0] count_q, count_d;
  logic [LWIDTH:0]     odim_m1;
  logic                col_end;
  logic                row_end;

  assign odim_m1 = odim_i - (LWIDTH + 1)'(1);
  assign col_end = ({1'b0, col_q} == odim_m1);
  assign row_end = ({1'b0, row_q} == odim_m1);

  assign row_o   = row_q;
  assign col_o   = col_q;
  assign count_o = count_q;
  assign last_o  = col_end && row_end;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    row_d   = row_q;
    col_d   = col_q;
    count_d = count_q;
    if (clr_i) begin
      row_d   = '0;
      col_d   = '0;
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNTWIDTH'(1);
      if (col_end) begin
        col_d = '0;
        row_d = row_q + LWIDTH'(1);
      end else begin
        col_d = col_q + LWIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      count_q <= count_d;
    end
  end

endmodule : renkon_win_counter

// File: rtl/renkon_linebuf_ctrl.sv
// -----------------------------------------------------------------------------
// renkon_linebuf_ctrl
// Layer sequencer for renkon_linebuf_pad. Accepts one layer command and runs
// the line buffer once per input channel: latches geometry, pulses buf_req,
// streams feature-memory read addresses while the line buffer consumes pixels,
// tags emitted windows with (row, col, channel) and pulses ack at the end.
//   clk, rst        : clock, synchronous active-high reset
//   req / ack       : layer start (sampled in S_IDLE only) / one-cycle done
//   img_size, fil_size, pad_size, n_in, in_base : layer command
//   err             : sticky config / window-count error, cleared on req
//   buf_req         : one-cycle plane start to the line buffer
//   buf_*_size      : latched geometry for the line buffer
//   buf_ready/valid/ack : line buffer consume / window valid / plane done
//   mem_addr        : feature-memory read address (1-cycle read latency)
//   win_valid/row/col/ch/last : registered window tag for the MAC array
// -----------------------------------------------------------------------------
module renkon_linebuf_ctrl
  import renkon_pkg::*;
#(
  parameter int MEMWIDTH = 16,
  parameter int CHWIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  output logic                ack,
  input  logic [LWIDTH-1:0]   img_size,
  input  logic [LWIDTH-1:0]   fil_size,
  input  logic [LWIDTH-1:0]   pad_size,
  input  logic [CHWIDTH-1:0]  n_in,
  input  logic [MEMWIDTH-1:0] in_base,
  output logic                err,
  output logic                buf_req,
  output logic [LWIDTH-1:0]   buf_img_size,
  output logic [LWIDTH-1:0]   buf_fil_size,
  output logic [LWIDTH-1:0]   buf_pad_size,
  input  logic                buf_ready,
  input  logic                buf_valid,
  input  logic                buf_ack,
  output logic [MEMWIDTH-1:0] mem_addr,
  output logic                win_valid,
  output logic [LWIDTH-1:0]   win_row,
  output logic [LWIDTH-1:0]   win_col,
  output logic [CHWIDTH-1:0]  win_ch,
  output logic                win_last
);

  localparam int PWIDTH = 2 * LWIDTH;

  state_e              state_q, state_d;
  logic [LWIDTH-1:0]   img_q, fil_q, pad_q;
  logic [CHWIDTH-1:0]  n_in_q;
  logic [MEMWIDTH-1:0] chan_base_q, chan_base_d;
  logic [PWIDTH-1:0]   plane_q;
  logic [LWIDTH:0]     odim_q;
  logic [PWIDTH-1:0]   pix_q, pix_d;
  logic [CHWIDTH-1:0]  ch_q, ch_d;
  logic                err_q, err_d;
  logic                latch_cfg;
  logic                load_derived;

  logic                win_valid_q, win_last_q;
  logic [LWIDTH-1:0]   win_row_q, win_col_q;
  logic [CHWIDTH-1:0]  win_ch_q;

  // Geometry derived from the latched command. span needs two extra bits
  // because img + 2*pad can exceed LWIDTH+1 bits.
  logic [LWIDTH+1:0]   span, fil_ext;
  logic                cfg_bad;
  logic [LWIDTH:0]     odim_calc;
  logic [PWIDTH-1:0]   plane_calc;
  logic [CNTWIDTH-1:0] odim_sq;

  logic                feeding;
  logic                win_inc;
  logic                pix_at_end;
  logic                last_ch;
  logic [LWIDTH-1:0]   cnt_row, cnt_col;
  logic [CNTWIDTH-1:0] cnt_count;
  logic                cnt_last;

  assign span       = {2'b00, img_q} + {1'b0, pad_q, 1'b0};
  assign fil_ext    = {2'b00, fil_q};
  assign cfg_bad    = (fil_q == '0) || (fil_ext > span);
  assign odim_calc  = (LWIDTH + 1)'(span - fil_ext + (LWIDTH + 2)'(1));
  assign plane_calc = PWIDTH'(img_q) * PWIDTH'(img_q);
  assign odim_sq    = CNTWIDTH'(odim_q) * CNTWIDTH'(odim_q);

  assign feeding    = (state_q == S_FEED);
  assign win_inc    = feeding && buf_valid;
  // Saturate one short of the plane end so a late buf_ready re-reads the
  // last pixel instead of stepping into the next channel's plane.
  assign pix_at_end = ((pix_q + PWIDTH'(1)) >= plane_q);
  assign last_ch    = (ch_q == n_in_q - CHWIDTH'(1));

  renkon_win_counter u_win_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   ((state_q == S_LOAD) || (state_q == S_NEXT)),
    .inc_i   (win_inc),
    .odim_i  (odim_q),
    .row_o   (cnt_row),
    .col_o   (cnt_col),
    .count_o (cnt_count),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    chan_base_d  = chan_base_q;
    pix_d        = pix_q;
    ch_d         = ch_q;
    err_d        = err_q;
    latch_cfg    = 1'b0;
    load_derived = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          latch_cfg   = 1'b1;
          err_d       = 1'b0;
          chan_base_d = in_base;
          ch_d        = '0;
          pix_d       = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        load_derived = 1'b1;
        if (n_in_q == '0) begin
          state_d = S_DONE;
        end else if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        pix_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (buf_ready && !pix_at_end) begin
          pix_d = pix_q + PWIDTH'(1);
        end
        if (buf_ack) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (cnt_count != odim_sq) begin
          err_d = 1'b1;
        end
        chan_base_d = chan_base_q + MEMWIDTH'(plane_q);
        ch_d        = ch_q + CHWIDTH'(1);
        state_d     = last_ch ? S_DONE : S_REQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      img_q       <= '0;
      fil_q       <= '0;
      pad_q       <= '0;
      n_in_q      <= '0;
      chan_base_q <= '0;
      plane_q     <= '0;
      odim_q      <= '0;
      pix_q       <= '0;
      ch_q        <= '0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      chan_base_q <= chan_base_d;
      pix_q       <= pix_d;
      ch_q        <= ch_d;
      err_q       <= err_d;
      if (latch_cfg) begin
        img_q  <= img_size;
        fil_q  <= fil_size;
        pad_q  <= pad_size;
        n_in_q <= n_in;
      end
      if (load_derived) begin
        plane_q <= plane_calc;
        odim_q  <= odim_calc;
      end
      win_valid_q <= win_inc;
      win_last_q  <= win_inc && cnt_last && last_ch;
      if (win_inc) begin
        win_row_q <= cnt_row;
        win_col_q <= cnt_col;
        win_ch_q  <= ch_q;
      end
    end
  end

  // The address looks ahead by the current consume so that, with the
  // memory's one-cycle latency, the next cycle's buf_input is the next pixel.
  assign mem_addr = ((state_q == S_REQ) || feeding) ?
                    chan_base_q + MEMWIDTH'(pix_d) : '0;

  assign ack          = (state_q == S_DONE);
  assign buf_req      = (state_q == S_REQ);
  assign err          = err_q;
  assign buf_img_size = img_q;
  assign buf_fil_size = fil_q;
  assign buf_pad_size = pad_q;
  assign win_valid    = win_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
  assign win_ch       = win_ch_q;
  assign win_last     = win_last_q;

endmodule : renkon_linebuf_ctrl
